// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: DEPTH-stage elastic pipeline register, per-stage valid, bubble collapse, flush.
// Latency: DEPTH cycles from acceptance to out_valid; one extra when a word waits in the skid entry.
// Backpressure: combinational ready chain back from out_ready; PIPE_REG_CHAIN_SKID_EN makes in_ready a flop.
module pipe_reg_chain #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic [$clog2(DEPTH+2)-1:0] occupancy
);

   localparam int OCC_W = $clog2(DEPTH+2);

   // Stage state: index 0 is the input side, DEPTH-1 drives the outputs.
   logic [DEPTH-1:0] v;
   logic [WIDTH-1:0] d [DEPTH];

   // Per-stage ready, and what each stage would load if it loads this cycle.
   logic [DEPTH-1:0] r;
   logic [DEPTH-1:0] up_vld;
   logic [WIDTH-1:0] up_dat [DEPTH];

   // Source feeding stage 0 (either the upstream port or the skid entry).
   logic             s0_src_vld;
   logic [WIDTH-1:0] s0_src_dat;

   logic in_xfer;
   logic out_xfer;

   assign out_valid = v[DEPTH-1];
   assign out_data  = d[DEPTH-1];
   assign out_xfer  = out_valid && out_ready;

   // Ready ripples back from the output: an empty stage, or one whose
   // successor is moving, can take a new word, so bubbles collapse.
   always_comb begin
      r = '0;
      r[DEPTH-1] = !v[DEPTH-1] || out_ready;
      for (int i = DEPTH-2; i >= 0; i--) begin
         r[i] = !v[i] || r[i+1];
      end
   end

   // Each stage's upstream neighbour: stage 0 sees the input source,
   // every other stage sees the stage before it.
   always_comb begin
      up_vld = '0;
      for (int i = 0; i < DEPTH; i++) begin
         up_dat[i] = '0;
      end
      up_vld[0] = s0_src_vld;
      up_dat[0] = s0_src_dat;
      for (int i = 1; i < DEPTH; i++) begin
         up_vld[i] = v[i-1];
         up_dat[i] = d[i-1];
      end
   end

`ifdef PIPE_REG_CHAIN_SKID_EN
   // Skid entry in front of stage 0; lets in_ready come from a flop.
   logic             sv;
   logic [WIDTH-1:0] sd;

   assign in_ready   = !sv && !flush;
   assign in_xfer    = in_valid && in_ready;
   // While the skid holds a word it is the only source for stage 0; in_ready
   // is low then, so in_data can never compete with it.
   assign s0_src_vld = sv || in_xfer;
   assign s0_src_dat = sv ? sd : in_data;

   // Park an accepted word when stage 0 is blocked; release it once stage 0 loads.
   always_ff @(posedge clk) begin
      if (rst) begin
         sv <= 1'b0;
         sd <= '0;
      end else if (flush) begin
         sv <= 1'b0;
      end else if (sv) begin
         if (r[0]) begin
            sv <= 1'b0;
         end
      end else if (in_xfer && !r[0]) begin
         sv <= 1'b1;
         sd <= in_data;
      end
   end
`else
   assign in_ready   = r[0] && !flush;
   assign in_xfer    = in_valid && in_ready;
   assign s0_src_vld = in_xfer;
   assign s0_src_dat = in_data;
`endif

   // Stage registers: flush drops valids but leaves data alone; data is only
   // written when a valid word actually moves in, so idle stages hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         v <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            d[i] <= '0;
         end
      end else if (flush) begin
         v <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (r[i]) begin
               v[i] <= up_vld[i];
               if (up_vld[i]) begin
                  d[i] <= up_dat[i];
               end
            end
         end
      end
   end

   // Entry count including the skid word: +1 per accept, -1 per departure.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         occupancy <= '0;
      end else if (in_xfer && !out_xfer) begin
         occupancy <= occupancy + OCC_W'(1);
      end else if (!in_xfer && out_xfer) begin
         occupancy <= occupancy - OCC_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb_pipe_reg_chain: directed stimulus with a queue scoreboard for pipe_reg_chain (WIDTH=8, DEPTH=3).
// Driver pushes each accepted word; a negedge monitor pops and compares on every out-transfer.
// Occupancy is compared each cycle against the scoreboard depth.
module tb_pipe_reg_chain;

   localparam int WIDTH = 8;
   localparam int DEPTH = 3;
   localparam int OCC_W = $clog2(DEPTH+2);
`ifdef PIPE_REG_CHAIN_SKID_EN
   localparam int CAP = DEPTH + 1;
`else
   localparam int CAP = DEPTH;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [OCC_W-1:0] occupancy;

   typedef struct {
      logic [7:0] dat;
      int         cyc;
      bit         lat;
   } exp_t;

   exp_t expq[$];
   exp_t mon_e;
   int   checks   = 0;
   int   failures = 0;
   int   cyc_cnt  = 0;
   int   max_occ  = 0;
   int   bp_idx   = 0;
   bit   occ_en   = 1'b0;
   bit   lat_mode = 1'b0;
   logic acc;
   logic ov;

   pipe_reg_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc_cnt++;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // One clock cycle of stimulus; called just after a rising edge.
   task automatic step(input bit iv, input logic [7:0] id, input bit ordy, input bit fl,
                       output logic acc_o, output logic ov_o);
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
      flush     = fl;
      @(negedge clk);
      acc_o = in_valid && in_ready;
      ov_o  = out_valid;
      if (acc_o) expq.push_back('{dat: id, cyc: cyc_cnt, lat: lat_mode});
      @(posedge clk);
      if (rst || fl) expq.delete();
      #1;
   endtask

   task automatic idle(input bit ordy, input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, ordy, 1'b0, acc, ov);
   endtask

   // Monitor: every out-transfer must match the oldest outstanding word.
   always @(negedge clk) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         if (expq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out: got 0x%0h expected no output", out_data);
         end else begin
            mon_e = expq.pop_front();
            check("out_data_order", int'(out_data), int'(mon_e.dat));
            if (mon_e.lat) check("latency", cyc_cnt - mon_e.cyc, DEPTH);
         end
      end
   end

   // Occupancy must equal the number of words accepted but not yet delivered.
   always @(posedge clk) begin
      #2;
      if (occ_en) begin
         check("occupancy", int'(occupancy), expq.size());
         if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, bench did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;

      // Reset held with random inputs
      for (int i = 0; i < 2; i++) begin
         step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), acc, ov);
      end
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_data", int'(out_data), 'h00);
      check("rst_occupancy", int'(occupancy), 0);
      check("rst_in_ready", int'(in_ready), 1);
      occ_en = 1'b1;

      // Streaming: three back-to-back words, latency DEPTH each
      max_occ  = 0;
      lat_mode = 1'b1;
      step(1'b1, 8'h11, 1'b1, 1'b0, acc, ov); check("stream_acc_11", int'(acc), 1);
      step(1'b1, 8'h22, 1'b1, 1'b0, acc, ov); check("stream_acc_22", int'(acc), 1);
      step(1'b1, 8'h33, 1'b1, 1'b0, acc, ov); check("stream_acc_33", int'(acc), 1);
      lat_mode = 1'b0;
      idle(1'b1, 5);
      check("stream_peak_occ", max_occ, 3);

      // Backpressure: fill to capacity, then drain with no gaps
      bp_idx = 0;
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 8'hA0 + 8'(bp_idx), 1'b0, 1'b0, acc, ov);
         if (acc) bp_idx++;
      end
      check("bp_accepted", bp_idx, CAP);
      check("bp_full_in_ready", int'(in_ready), 0);
      check("bp_full_occ", int'(occupancy), CAP);
      check("bp_head_data", int'(out_data), 'hA0);
      for (int i = 0; i < 5; i++) begin
         step(bp_idx < 5, 8'hA0 + 8'(bp_idx), 1'b1, 1'b0, acc, ov);
         if (acc) bp_idx++;
         check("bp_drain_no_gap", int'(ov), 1);
      end
      check("bp_all_accepted", bp_idx, 5);
      idle(1'b1, 4);

      // Bubble collapse: 0x01, two idle cycles, 0x02, all stalled
      step(1'b1, 8'h01, 1'b0, 1'b0, acc, ov); check("bub_acc_01", int'(acc), 1);
      idle(1'b0, 2);
      step(1'b1, 8'h02, 1'b0, 1'b0, acc, ov); check("bub_acc_02", int'(acc), 1);
      step(1'b0, 8'h00, 1'b0, 1'b0, acc, ov);
      check("bub_occ", int'(occupancy), 2);
      check("bub_in_ready", int'(in_ready), 1);
      check("bub_out_valid", int'(out_valid), 1);
      check("bub_out_data", int'(out_data), 'h01);
      idle(1'b0, 1);
      check("bub_hold_data", int'(out_data), 'h01);
      idle(1'b1, 4);

      // Flush: fill three words, flush while offering 0xFF; head departure honoured
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 8'hB1 + 8'(i), 1'b0, 1'b0, acc, ov);
         check("flush_fill_acc", int'(acc), 1);
      end
      step(1'b1, 8'hFF, 1'b1, 1'b1, acc, ov);
      check("flush_no_accept", int'(acc), 0);
      check("flush_out_honoured", int'(ov), 1);
      check("flush_out_valid", int'(out_valid), 0);
      check("flush_occ", int'(occupancy), 0);
      check("flush_data_kept", int'(out_data), 'hB1);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 8'h00, 1'b1, 1'b0, acc, ov);
         check("flush_no_output", int'(ov), 0);
      end

      // Mid-stream reset with two words in flight
      step(1'b1, 8'h55, 1'b1, 1'b0, acc, ov); check("mrst_acc_55", int'(acc), 1);
      step(1'b1, 8'h66, 1'b1, 1'b0, acc, ov); check("mrst_acc_66", int'(acc), 1);
      rst = 1'b1;
      step(1'b0, 8'h00, 1'b1, 1'b0, acc, ov);
      rst = 1'b0;
      check("mrst_out_valid", int'(out_valid), 0);
      check("mrst_out_data", int'(out_data), 'h00);
      check("mrst_occ", int'(occupancy), 0);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 8'h00, 1'b1, 1'b0, acc, ov);
         check("mrst_no_output", int'(ov), 0);
      end

      check("scoreboard_drained", expq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
